// File: rtl/simon_param_core.sv
// ---------------------------------------------------------------------------
// simon_param_core
//   Iterative SIMON 2N/MN block cipher core, parametrised over all ten
//   published variants. A newKey request expands the key schedule once into
//   a round-key register file, one round key per clock. After that,
//   encryption or decryption blocks run one round per clock from that file.
//
// Parameters
//   N   word size (block = 2N bits)    M  key words
//   T   rounds                         J  z-sequence index
//   CW  round/key counter width
//
// Ports
//   clk       rising-edge clock
//   nR        asynchronous active-low reset
//   newKey    key load request (level, one acceptance per high period)
//   key       key words, key[0] = k0
//   ldKey     one-cycle pulse, key captured
//   doneKey   round keys valid (level)
//   newData   block load request (level, one acceptance per high period)
//   enc_dec   1 = encrypt, 0 = decrypt, sampled together with plain
//   plain     input block, x = [2N-1:N], y = [N-1:0]
//   ldData    one-cycle pulse, block captured
//   doneData  cipher valid, held until readData
//   readData  host has consumed cipher
//   cipher    result block, same x/y layout
// ---------------------------------------------------------------------------
module simon_param_core #(
  parameter int N  = 64,
  parameter int M  = 3,
  parameter int T  = 69,
  parameter int J  = 3,
  parameter int CW = 7
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] key,
  output logic                ldKey,
  output logic                doneKey,
  input  logic                newData,
  input  logic                enc_dec,
  input  logic [2*N-1:0]      plain,
  output logic                ldData,
  output logic                doneData,
  input  logic                readData,
  output logic [2*N-1:0]      cipher
);

  localparam int AW = $clog2(T);

  localparam bit TUPLE_OK =
    (N == 16 && M == 4 && T == 32 && J == 0) || (N == 24 && M == 3 && T == 36 && J == 0) ||
    (N == 24 && M == 4 && T == 36 && J == 1) || (N == 32 && M == 3 && T == 42 && J == 2) ||
    (N == 32 && M == 4 && T == 44 && J == 3) || (N == 48 && M == 2 && T == 52 && J == 2) ||
    (N == 48 && M == 3 && T == 54 && J == 3) || (N == 64 && M == 2 && T == 68 && J == 2) ||
    (N == 64 && M == 3 && T == 69 && J == 3) || (N == 64 && M == 4 && T == 72 && J == 4);

  if (!TUPLE_OK) begin : g_bad_tuple
    $error("simon_param_core: (N,M,T,J) is not a published SIMON variant");
  end
  if ((2 ** CW) < (T + 1)) begin : g_bad_cw
    $error("simon_param_core: CW too narrow for T");
  end

  // z sequences, element 0 is the leftmost (MSB) bit as printed.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] ZSEQ = (J == 0) ? Z0 : (J == 1) ? Z1 : (J == 2) ? Z2 : (J == 3) ? Z3 : Z4;

  localparam logic [1:0] K_IDLE = 2'd0, K_EXP = 2'd1, K_RDY = 2'd2;
  localparam logic [1:0] D_IDLE = 2'd0, D_RUN = 2'd1, D_DONE = 2'd2;

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int unsigned s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int unsigned s);
    return (a >> s) | (a << (N - s));
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  logic [1:0]    kst_q, kst_d, dst_q, dst_d;
  logic [CW-1:0] ki_q, r_q;
  logic [5:0]    zi_q;                 // (i-M) mod 62, tracked beside ki_q
  logic          key_arm_q, ld_key_q, done_key_q;
  logic          data_arm_q, ld_data_q, done_data_q, mode_q;
  logic [N-1:0]  x_q, y_q;
  logic [2*N-1:0] cipher_q;
  logic [N-1:0]  rk_q [T];

  logic          key_acc, data_acc;
  logic [N-1:0]  tmp, rk_new, rk_rnd, x_rnd, y_rnd;

  // newKey wins over newData on the same edge; a block never starts while
  // the schedule is being rebuilt because data_acc needs doneKey.
  assign key_acc  = newKey & key_arm_q & (kst_q != K_EXP) & (dst_q == D_IDLE);
  assign data_acc = newData & data_arm_q & done_key_q & (dst_q == D_IDLE) & ~key_acc;

  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    kst_d = kst_q;
    if (key_acc)                                     kst_d = K_EXP;
    else if (kst_q == K_EXP && ki_q == CW'(T - 1))   kst_d = K_RDY;

    dst_d = dst_q;
    case (dst_q)
      D_IDLE:  if (data_acc)              dst_d = D_RUN;
      D_RUN:   if (r_q == CW'(T - 1))     dst_d = D_DONE;
      D_DONE:  if (readData)              dst_d = D_IDLE;
      default:                            dst_d = D_IDLE;
    endcase
  end

  // Key schedule step for rk[ki_q].
  always_comb begin
    tmp = ror(rk_q[AW'(ki_q - CW'(1))], 3);
    if (M == 4) tmp = tmp ^ rk_q[AW'(ki_q - CW'(3))];
    tmp    = tmp ^ ror(tmp, 1);
    rk_new = ~rk_q[AW'(ki_q - CW'(M))] ^ tmp ^ {{(N-1){1'b0}}, ZSEQ[6'd61 - zi_q]} ^ N'(3);
  end

  // One Feistel round; decryption walks the schedule backwards.
  always_comb begin
    rk_rnd = mode_q ? rk_q[AW'(r_q)] : rk_q[AW'(CW'(T - 1) - r_q)];
    if (mode_q) begin
      x_rnd = y_q ^ f(x_q) ^ rk_rnd;
      y_rnd = x_q;
    end else begin
      x_rnd = y_q;
      y_rnd = x_q ^ f(y_q) ^ rk_rnd;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      kst_q      <= K_IDLE;
      ki_q       <= '0;
      zi_q       <= '0;
      key_arm_q  <= 1'b1;
      ld_key_q   <= 1'b0;
      done_key_q <= 1'b0;
    end else begin
      kst_q     <= kst_d;
      ld_key_q  <= key_acc;
      // Re-arm only once the request has been seen low.
      key_arm_q <= key_acc ? 1'b0 : (key_arm_q | ~newKey);
      if (key_acc) begin
        ki_q       <= CW'(M);
        zi_q       <= '0;
        done_key_q <= 1'b0;
      end else if (kst_q == K_EXP) begin
        ki_q <= ki_q + CW'(1);
        zi_q <= (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
        if (ki_q == CW'(T - 1)) done_key_q <= 1'b1;
      end
    end
  end

  // NOTE: the round-key file has no reset; doneKey guards its contents, and
  // leaving it unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      for (int i = 0; i < M; i++) rk_q[i] <= key[i];
    end else if (kst_q == K_EXP) begin
      rk_q[AW'(ki_q)] <= rk_new;
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      dst_q       <= D_IDLE;
      r_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      data_arm_q  <= 1'b1;
      ld_data_q   <= 1'b0;
      done_data_q <= 1'b0;
      cipher_q    <= '0;
    end else begin
      dst_q      <= dst_d;
      ld_data_q  <= data_acc;
      data_arm_q <= data_acc ? 1'b0 : (data_arm_q | ~newData);
      case (dst_q)
        D_IDLE: if (data_acc) begin
          x_q    <= plain[2*N-1:N];
          y_q    <= plain[N-1:0];
          mode_q <= enc_dec;
          r_q    <= '0;
        end
        D_RUN: begin
          x_q <= x_rnd;
          y_q <= y_rnd;
          r_q <= r_q + CW'(1);
          if (r_q == CW'(T - 1)) begin
            cipher_q    <= {x_rnd, y_rnd};
            done_data_q <= 1'b1;
          end
        end
        D_DONE: if (readData) done_data_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ldKey    = ld_key_q;
  assign doneKey  = done_key_q;
  assign ldData   = ld_data_q;
  assign doneData = done_data_q;
  assign cipher   = cipher_q;

endmodule
